// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// The core stalls on wait_sig; a cycle counter aborts accesses the memory never completes.
module mem_arbiter #(
  parameter logic [15:0] TIMEOUT   = 16'd1023,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  input  logic        data_access,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_data_sig,
  output logic [31:0] read_data,
  output logic        wait_sig,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        data_done;
  logic        in_access;
  logic        done;
  logic        timed_out;
  logic        commit_now;

  assign fsm_state = state;

  // Memory handshake: a request (mem_req with address/we/wdata) is held
  // unchanged until the edge at which mem_ready=1 completes it, or until the
  // wait counter aborts it; mem_ready is only looked at while mem_req=1.
  always_comb begin
    in_access   = (state == FETCH) || (state == DATA);
    done        = in_access && mem_ready;
    timed_out   = in_access && !mem_ready && (wait_cnt == TIMEOUT);
    // COMMIT doubles as the decision step: an undone data access diverts to DATA.
    commit_now  = (state == COMMIT) && !(data_access && !data_done);

    state_nxt   = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_address = 32'h0;
    mem_wdata   = 32'h0;
    wait_sig    = 1'b1;

    case (state)
      IDLE:   state_nxt = FETCH;
      FETCH:  if (done || timed_out) state_nxt = COMMIT;
      DATA:   if (done || timed_out) state_nxt = COMMIT;
      COMMIT: state_nxt = commit_now ? FETCH : DATA;
      default: state_nxt = IDLE;
    endcase

    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req     = 1'b1;
          mem_address = pc;
        end
        DATA: begin
          mem_req     = 1'b1;
          mem_we      = write_data_sig;
          mem_address = address;
          mem_wdata   = write_data;
        end
        COMMIT:  wait_sig = !commit_now;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      instruction <= NOP_INSTR;
      read_data   <= 32'h0;
      bus_error   <= 1'b0;
      wait_cnt    <= 16'h0;
      data_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_error <= timed_out;

      if (!in_access && ((state_nxt == FETCH) || (state_nxt == DATA)))
        wait_cnt <= 16'h0;
      else if (in_access && !mem_ready)
        wait_cnt <= wait_cnt + 16'd1;

      if (state == FETCH) begin
        if (mem_ready)      instruction <= mem_rdata;
        else if (timed_out) instruction <= NOP_INSTR;
      end

      // Stores never touch read_data, whether they complete or abort.
      if (state == DATA && !write_data_sig) begin
        if (mem_ready)      read_data <= mem_rdata;
        else if (timed_out) read_data <= 32'h0;
      end

      if ((state == DATA && (done || timed_out)) || (state == FETCH && timed_out))
        data_done <= 1'b1;
      else if (commit_now)
        data_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of instructions served by a cycle-driven memory
// responder, expected commit results queued at issue and compared at commit.
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        data_access;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_data_sig;
  logic [31:0] read_data;
  logic        wait_sig;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_mem;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          fd;
    int          dd;
    logic [31:0] exp_instr;
    logic [31:0] exp_rd;
    logic        exp_be;
  } vec_t;

  vec_t vecs[8];

  mem_arbiter #(.TIMEOUT(16'(TO)), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .data_access(data_access), .address(address), .write_data(write_data),
    .write_data_sig(write_data_sig), .read_data(read_data), .wait_sig(wait_sig),
    .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .fsm_state(fsm_state)
  );

  // Core-side decode of the latched instruction (load 0x03, store 0x23).
  assign data_access    = (instruction[6:0] == 7'h03) || (instruction[6:0] == 7'h23);
  assign write_data_sig = (instruction[6:0] == 7'h23);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] ins,
                              input logic mem, input logic st, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int fd,
                              input int dd, input logic [31:0] ei, input logic [31:0] er,
                              input logic eb);
    vec_t v;
    v.pc = p; v.instr = ins; v.is_mem = mem; v.is_store = st; v.addr = a;
    v.wdata = wd; v.rdata = rd; v.fd = fd; v.dd = dd;
    v.exp_instr = ei; v.exp_rd = er; v.exp_be = eb;
    return v;
  endfunction

  // Entered at posedge+1 with the DUT in a request state; returns at posedge+1
  // of the cycle after the request completes or is aborted.
  task automatic serve(input string ph, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input int delay, input logic [31:0] rd);
    int n;
    n = (delay > TO) ? TO + 1 : delay + 1;
    for (int k = 0; k < n; k++) begin
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? rd : $urandom;
      #1;
      check({ph, " mem_req"}, 32'(mem_req), 32'd1);
      check({ph, " mem_address"}, mem_address, a);
      check({ph, " mem_we"}, 32'(mem_we), 32'(we));
      check({ph, " mem_wdata"}, mem_wdata, wd);
      check({ph, " wait_sig"}, 32'(wait_sig), 32'd1);
      check({ph, " bus_error"}, 32'(bus_error), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_instr(input vec_t v);
    logic [64:0] e;
    pc = v.pc;
    address = v.addr;
    write_data = v.wdata;
    exp_q.push_back({v.exp_be, v.exp_instr, v.exp_rd});
    serve("fetch", v.pc, 1'b0, 32'h0, v.fd, v.instr);
    if (v.is_mem && v.fd <= TO) begin
      #1;
      check("decide wait_sig", 32'(wait_sig), 32'd1);
      check("decide mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      serve("data", v.addr, v.is_store, v.wdata, v.dd, v.rdata);
    end
    #1;
    e = exp_q.pop_front();
    check("commit wait_sig", 32'(wait_sig), 32'd0);
    check("commit mem_req", 32'(mem_req), 32'd0);
    check("commit instruction", instruction, e[63:32]);
    check("commit read_data", read_data, e[31:0]);
    check("commit bus_error", 32'(bus_error), 32'(e[64]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = mk(32'h0,  32'h00500093, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        0, 0,
                 32'h00500093, 32'h0,        1'b0);
    vecs[1] = mk(32'h4,  32'h00002083, 1'b1, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 0, 0,
                 32'h00002083, 32'hCAFEF00D, 1'b0);
    vecs[2] = mk(32'h8,  32'h00002023, 1'b1, 1'b1, 32'h104, 32'h12345678, 32'h0,        0, 3,
                 32'h00002023, 32'hCAFEF00D, 1'b0);
    vecs[3] = mk(32'hC,  32'h00A00113, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        5, 0,
                 NOP,          32'hCAFEF00D, 1'b1);
    vecs[4] = mk(32'h10, 32'h00A00113, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        4, 0,
                 32'h00A00113, 32'hCAFEF00D, 1'b0);
    vecs[5] = mk(32'h14, 32'h00002083, 1'b1, 1'b0, 32'h180, 32'h0,        32'h11111111, 2, 6,
                 32'h00002083, 32'h0,        1'b1);
    vecs[6] = mk(32'h18, 32'h00002083, 1'b1, 1'b0, 32'h184, 32'h0,        32'h0BADBEEF, 1, 4,
                 32'h00002083, 32'h0BADBEEF, 1'b0);
    vecs[7] = mk(32'h1C, 32'h00002023, 1'b1, 1'b1, 32'h108, 32'h55AA55AA, 32'h0,        0, 5,
                 32'h00002023, 32'h0BADBEEF, 1'b1);

    rst_n = 1'b0;
    pc = 32'h0;
    address = 32'h0;
    write_data = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    step();
    step();
    check("reset wait_sig", 32'(wait_sig), 32'd1);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset instruction", instruction, NOP);
    check("reset read_data", read_data, 32'h0);
    check("reset bus_error", 32'(bus_error), 32'd0);
    check("reset state", 32'(fsm_state), 32'd0);

    rst_n = 1'b1;
    #1;
    check("idle mem_req", 32'(mem_req), 32'd0);
    check("idle wait_sig", 32'(wait_sig), 32'd1);
    step();

    for (int i = 0; i < 8; i++) run_instr(vecs[i]);

    // Reset arriving while a load is stuck waiting in its data phase.
    pc = 32'h40;
    address = 32'h200;
    serve("rst fetch", 32'h40, 1'b0, 32'h0, 0, 32'h00002083);
    step();
    for (int k = 0; k < 2; k++) begin
      check("rst data mem_req", 32'(mem_req), 32'd1);
      check("rst data mem_address", mem_address, 32'h200);
      step();
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ready = 1'b0;
    check("midrst mem_req", 32'(mem_req), 32'd0);
    check("midrst read_data", read_data, 32'h0);
    check("midrst instruction", instruction, NOP);
    check("midrst bus_error", 32'(bus_error), 32'd0);
    check("midrst state", 32'(fsm_state), 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst idle mem_req", 32'(mem_req), 32'd0);
    step();
    check("restart mem_req", 32'(mem_req), 32'd1);
    check("restart mem_address", mem_address, 32'h40);
    check("restart state", 32'(fsm_state), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1023: maximum cycles to wait for mem_ready before aborting an access.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: instruction word returned on reset or fetch abort.
REQ-003 SHALL run on one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 pc  in  32  core fetch address.
REQ-007 instruction  out  32  latched instruction word to core.
REQ-008 data_access  in  1  core requests a data access for the current instruction.
REQ-009 address  in  32  core data address.
REQ-010 write_data  in  32  core store data.
REQ-011 write_data_sig  in  1  1 = store, 0 = load; valid while data_access is 1.
REQ-012 read_data  out  32  latched load data to core.
REQ-013 wait_sig  out  1  1 = core holds pc and register writeback.
REQ-014 bus_error  out  1  one-cycle pulse when an access is aborted by timeout.
REQ-015 mem_req  out  1  shared single-port memory request.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_address  out  32  memory address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_rdata  in  32  memory read data, valid when mem_ready is 1.
REQ-020 mem_ready  in  1  memory completes the current request at this edge.

Function
REQ-021 SHALL use FSM states IDLE, FETCH, DATA, COMMIT, held in registers.
REQ-022 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-023 FETCH SHALL drive mem_req=1, mem_we=0, mem_address=pc, and mem_wdata=0.
REQ-024 FETCH with mem_ready=1 SHALL latch instruction=mem_rdata, then go to DATA if the post-latch data_access=1, else to COMMIT.
REQ-025 Because data_access decodes combinationally from the latched instruction, the FETCH-to-DATA decision SHALL be taken one cycle later: FETCH goes to a one-cycle decision step inside COMMIT, where data_access=1 gives DATA and 0 gives a commit.
REQ-026 Resolution of REQ-024/REQ-025, binding: FETCH completion always goes to COMMIT; in COMMIT, data_access=1 with the data phase not yet done goes to DATA with wait_sig held 1; otherwise it commits.
REQ-027 DATA SHALL drive mem_req=1, mem_we=write_data_sig, mem_address=address, and mem_wdata=write_data.
REQ-028 DATA with mem_ready=1 SHALL latch read_data=mem_rdata on a load (left unchanged on a store), set the data-done flag, and go to COMMIT.
REQ-029 A commit cycle SHALL drive wait_sig=0 for exactly one cycle, clear the data-done flag, and go to FETCH.
REQ-030 wait_sig SHALL be 1 in every cycle other than a commit cycle.
REQ-031 mem_req SHALL be 1 only in FETCH and DATA.
REQ-032 mem_address, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-033 mem_ready SHALL be ignored while mem_req=0.
REQ-034 A 16-bit wait counter SHALL clear on entry to FETCH or DATA and increment each cycle mem_ready=0.
REQ-035 When the counter equals TIMEOUT and mem_ready=0, the FSM SHALL abort to COMMIT with data-done set.
REQ-036 A fetch abort SHALL set instruction=NOP_INSTR.
REQ-037 A load abort SHALL set read_data=0.
REQ-038 A store abort SHALL perform no write beyond the cycles already driven.
REQ-039 An abort SHALL pulse bus_error=1 for the following cycle only.
REQ-040 If mem_ready=1 in the same cycle the counter reaches TIMEOUT, completion SHALL win: no abort, no bus_error.
REQ-041 Zero-wait-state latency SHALL be 2 cycles per non-memory instruction and 4 cycles per load/store, from FETCH entry to commit.

Reset
REQ-042 rst_n=0 at an edge SHALL force state=IDLE, instruction=NOP_INSTR, read_data=0, bus_error=0, counter=0, and data-done=0.
REQ-043 During reset and IDLE, outputs SHALL be wait_sig=1 and mem_req=0.
REQ-044 Reset mid-access SHALL drop mem_req at the next edge, and no latched value SHALL update from that access.

Verification
REQ-045 Reset then pc=0, mem_ready always 1, mem_rdata=32'h00500093 -> one mem_req fetch at address 0, instruction=32'h00500093, wait_sig=0 exactly 2 cycles after IDLE exit.
REQ-046 Load instruction with address=32'h100, mem_rdata=32'hCAFEF00D on the data phase -> mem_address=32'h100, mem_we=0, read_data=32'hCAFEF00D at commit.
REQ-047 Store with address=32'h104, write_data=32'h12345678, mem_ready delayed 3 cycles -> mem_we=1 with address and data stable for 4 cycles, a single commit, read_data unchanged.
REQ-048 TIMEOUT=4, mem_ready held 0 during fetch -> abort after 5 request cycles, instruction=32'h00000013, bus_error one-cycle pulse, then next FETCH.
REQ-049 TIMEOUT=4, mem_ready=1 on the exact timeout cycle -> normal completion, bus_error stays 0.
REQ-050 rst_n=0 asserted during a DATA wait -> mem_req=0 next cycle, read_data=0, and FETCH restarts after IDLE.
